pid_order_fifo: RTL and testbench
=================================

Name: pid_order_fifo

Overview:
- Parametrised successor to the fixed 8-bit PID ordering FIFO.
- Records the order in which packet PIDs (or any tag) arrive, so the downstream packet sequencer can consume them in arrival order.
- Adds over the fixed version: configurable width and any depth (power-of-2 not required), occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 8: bits per entry.
- DEPTH, 79: number of entries; any integer >= 2.
- AFULL_TH, 75: almost_full asserts when count >= AFULL_TH; range 1..DEPTH.
- AEMPTY_TH, 4: almost_empty asserts when count <= AEMPTY_TH; range 0..DEPTH-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents.
- w_enable  in  1  write request.
- w_data  in  WIDTH  write data.
- r_enable  in  1  read (pop) request.
- r_data  out  WIDTH  head entry, show-ahead.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  CW  occupancy, where CW = $clog2(DEPTH+1).
- overflow  out  1  sticky: a write was rejected because the FIFO was full.
- underflow  out  1  sticky: a read was rejected because the FIFO was empty.
- err_clr  in  1  clears overflow and underflow.

Behaviour:
- Reset (rst=1 at a rising edge):
  - wr_ptr = rd_ptr = 0, count = 0, overflow = underflow = 0.
  - Outputs after reset: empty=1, full=0, almost_empty=1, almost_full=0 (AFULL_TH >= 1), r_data=0.
  - rst overrides every other input, including mid-burst; memory contents need not be cleared.
- Priority per cycle: rst > flush > read/write.
- flush:
  - Same pointer/count effect as reset.
  - Error flags are kept.
  - Any w_enable/r_enable in the same cycle is ignored and flags no error.
- Write accepted when w_enable && (!full || r_enable):
  - mem[wr_ptr] <= w_data.
  - wr_ptr advances; after DEPTH-1 it wraps to 0 (explicit compare, no power-of-2 masking).
- Read accepted when r_enable && !empty:
  - rd_ptr advances with the same wrap rule.
- Count update:
  - Write only: count+1.
  - Read only: count-1.
  - Both accepted: unchanged.
- Full and simultaneous read+write: both accepted; count stays DEPTH; full stays 1.
- Empty and simultaneous read+write:
  - Write accepted, read rejected (no bypass).
  - Underflow is set; count becomes 1.
- Rejected write (w_enable && full && !r_enable): data dropped, overflow <= 1.
- Rejected read (r_enable && empty): pointers unchanged, underflow <= 1.
- err_clr: clears both error flags next cycle. If a new error occurs in the same cycle, the new error wins and the flag is set.
- r_data:
  - Combinational from mem[rd_ptr] when !empty; 0 when empty.
  - A word written at edge N is visible on r_data after edge N when the FIFO was empty, i.e. 1-cycle write-to-read latency.
- Flag timing: empty, full, almost_* and count are all registered-state derived and valid the cycle after the causing edge. No combinational path from w_enable/r_enable to any flag.
- Storage: a single register array of DEPTH x WIDTH; no extra sentinel slot.

Test Plan:
- Reset, then idle -> empty=1, almost_empty=1, count=0, r_data=0, full=0, overflow=0, underflow=0.
- Write 0x11..0x4F (63 words), then read all -> read order 0x11, 0x12, ... 0x4F. Around the writes:
  - almost_empty deasserts when count reaches 5.
  - empty returns after the last read.
  - underflow stays 0.
- Fill to 79 entries, then:
  - almost_full asserts at count=75; full at 79.
  - Extra write of 0xAA -> overflow=1, count=79, 0xAA never read.
  - err_clr -> overflow=0.
- With DEPTH full, pulse r_enable+w_enable (0x5C) for 200 cycles -> count stays 79, full stays 1, no errors. Drained data matches the write order, exercising rd/wr wrap at 78->0 multiple times.
- Empty FIFO, r_enable+w_enable with 0x3C -> count=1, underflow=1, r_data=0x3C next cycle.
- Load 10 entries, then:
  - flush with w_enable=1 -> count=0, empty=1, overflow/underflow unchanged.
  - Assert rst during a write burst -> all state reset next cycle, and the burst write in the rst cycle is not stored.

Source files
------------

// File: rtl/pid_order_fifo.sv
// Arrival-order tag FIFO: any depth, occupancy count, almost-full/empty flags,
// synchronous flush and sticky overflow/underflow error flags.
module pid_order_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 79,
    parameter int AFULL_TH  = 75,
    parameter int AEMPTY_TH = 4,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             w_enable,
    input  logic [WIDTH-1:0] w_data,
    input  logic             r_enable,
    output logic [WIDTH-1:0] r_data,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             w_acc, r_acc;

    // Flags decode only registered count, so no enable reaches them combinationally.
    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_full  = (count >= CW'(AFULL_TH));
    assign almost_empty = (count <= CW'(AEMPTY_TH));
    assign r_data       = empty ? '0 : mem[rd_ptr];

    // A full FIFO still takes a write when the head is popped the same cycle.
    assign w_acc = w_enable && (!full || r_enable);
    assign r_acc = r_enable && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (w_acc)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (r_acc)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({w_acc, r_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new error in the clearing cycle takes precedence over err_clr.
            if (w_enable && full && !r_enable)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;
            if (r_enable && empty)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && w_acc)
            mem[wr_ptr] <= w_data;
    end
endmodule

// File: tb/tb_pid_order_fifo.sv
// Scoreboard bench for pid_order_fifo: a queue model tracks contents, flags and
// sticky errors; every read pops and compares against the arrival order.
module tb_pid_order_fifo;
    localparam int WIDTH     = 8;
    localparam int DEPTH     = 79;
    localparam int AFULL_TH  = 75;
    localparam int AEMPTY_TH = 4;
    localparam int CW        = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0, flush = 1'b0, w_enable = 1'b0, r_enable = 1'b0, err_clr = 1'b0;
    logic [WIDTH-1:0] w_data = '0;
    logic [WIDTH-1:0] r_data;
    logic             empty, full, almost_full, almost_empty, overflow, underflow;
    logic [CW-1:0]    count;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [WIDTH-1:0] sb [$];
    logic             movf = 1'b0, mund = 1'b0;

    always #5 clk = ~clk;

    pid_order_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .w_enable(w_enable), .w_data(w_data),
        .r_enable(r_enable), .r_data(r_data), .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        int n;
        n = sb.size();
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(n >= AFULL_TH));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AEMPTY_TH));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("underflow", 32'(underflow), 32'(mund));
        if (n == 0) chk("r_data_empty", 32'(r_data), 32'd0);
        else        chk("r_data_head", 32'(r_data), 32'(sb[0]));
    endtask

    // Drive one cycle, update the model, then check state one delta after the edge.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                        input logic fl = 1'b0, input logic clr = 1'b0, input logic rs = 1'b0);
        logic full_m, empty_m;
        logic [WIDTH-1:0] e;
        w_enable = w; w_data = d; r_enable = r; flush = fl; err_clr = clr; rst = rs;
        #1;
        full_m  = (sb.size() == DEPTH);
        empty_m = (sb.size() == 0);
        if (rs) begin
            sb.delete();
            movf = 1'b0;
            mund = 1'b0;
        end else if (fl) begin
            sb.delete();
        end else begin
            if (r && !empty_m) begin
                e = sb.pop_front();
                chk("rd_order", 32'(r_data), 32'(e));
            end
            if (w && (!full_m || r)) sb.push_back(d);
            if (w && full_m && !r) movf = 1'b1;
            else if (clr)          movf = 1'b0;
            if (r && empty_m)      mund = 1'b1;
            else if (clr)          mund = 1'b0;
        end
        @(posedge clk);
        #1;
        w_enable = 1'b0; r_enable = 1'b0; flush = 1'b0; err_clr = 1'b0; rst = 1'b0;
        check_state();
    endtask

    initial begin
        step(0, '0, 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);
        step(0, '0, 0);

        for (int i = 0; i < 63; i++) step(1, 8'(8'h11 + i), 0);
        for (int i = 0; i < 63; i++) step(0, '0, 1);
        chk("underflow_after_drain", 32'(underflow), 32'd0);

        for (int i = 0; i < DEPTH; i++) step(1, 8'(i * 3 + 1), 0);
        step(1, 8'hAA, 0);
        chk("overflow_set", 32'(overflow), 32'd1);
        step(0, '0, 0, 0, 1);

        for (int i = 0; i < 200; i++) step(1, 8'(8'h5C + i), 1);
        for (int i = 0; i < DEPTH; i++) step(0, '0, 1);

        step(1, 8'h3C, 1);
        chk("bypass_blocked_rdata", 32'(r_data), 32'h3C);
        chk("bypass_underflow", 32'(underflow), 32'd1);
        step(0, '0, 1, 0, 1);
        step(1, 8'h21, 0);
        step(0, '0, 1);
        step(0, '0, 1, 0, 1);
        chk("clr_loses_to_new_err", 32'(underflow), 32'd1);

        for (int i = 0; i < 10; i++) step(1, 8'(8'hC0 + i), 0);
        step(1, 8'h99, 0, 1);
        chk("flush_keeps_underflow", 32'(underflow), 32'd1);
        step(0, '0, 1);

        for (int i = 0; i < 5; i++) step(1, 8'(8'hE0 + i), 0);
        step(1, 8'h77, 0, 0, 0, 1);
        step(1, 8'h42, 0);
        step(0, '0, 1);
        step(0, '0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
